// File: rtl/ctrl_pkg.sv
// Shared control-word encodings, default RegWrite/MemWrite bit positions and pipeline stage indices.
package ctrl_pkg;

  localparam int DEF_REGWR_BIT = 0;
  localparam int DEF_MEMWR_BIT = 4;
  localparam int MAX_STAGES    = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } aluCtrlT;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } resultSrcT;

  typedef enum int unsigned {
    EX  = 0,
    MEM = 1,
    WB  = 2
  } stageIdxT;

  // Smallest counter width able to hold the value n without wrapping.
  function automatic int cntWidthFor(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control-word pipeline register: flush, hold, bubble or load from the upstream slot.
module ctrl_pipe_stage #(
  parameter int CTRL_W    = 12,
  parameter int REGWR_BIT = 0,
  parameter int MEMWR_BIT = 4
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              iflush,
  input  logic              ihold,
  input  logic              iprevHold,
  input  logic [CTRL_W-1:0] iprevCtrl,
  input  logic              iprevVld,
  output logic [CTRL_W-1:0] octrl,
  output logic              ovld,
  output logic              onextVld,
  output logic              onextRegWr,
  output logic              onextMemWr
);

  logic [CTRL_W-1:0] ctrlNext;
  logic              vldNext;

  always_comb begin
    ctrlNext = octrl;
    vldNext  = ovld;
    if (iflush) begin
      ctrlNext = '0;
      vldNext  = 1'b0;
    end else if (!ihold) begin
      if (iprevHold) begin
        ctrlNext = '0;
        vldNext  = 1'b0;
      end else begin
        // An invalid slot always carries an all-zero word.
        ctrlNext = iprevVld ? iprevCtrl : '0;
        vldNext  = iprevVld;
      end
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      octrl <= '0;
      ovld  <= 1'b0;
    end else begin
      octrl <= ctrlNext;
      ovld  <= vldNext;
    end
  end

  assign onextVld   = vldNext;
  assign onextRegWr = vldNext & ctrlNext[REGWR_BIT];
  assign onextMemWr = vldNext & ctrlNext[MEMWR_BIT];

endmodule

// File: rtl/ctrl_pipe.sv
// Parametrised control-word pipeline with stall propagation, flush and pending-write tracking.
// Optional performance counters are enabled by defining CTRL_PIPE_PERF_EN.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int NSTAGES   = 3,
  parameter int CTRL_W    = 12,
  parameter int REGWR_BIT = DEF_REGWR_BIT,
  parameter int MEMWR_BIT = DEF_MEMWR_BIT,
  parameter int CNT_W     = 4
) (
  input  logic                      iclk,
  input  logic                      irst_n,
  input  logic [CTRL_W-1:0]         ictrl_d,
  input  logic                      ivld_d,
  input  logic [NSTAGES-1:0]        istall,
  input  logic [NSTAGES-1:0]        iflush,
  output logic [NSTAGES*CTRL_W-1:0] octrl,
  output logic [NSTAGES-1:0]        ovld,
  output logic [NSTAGES-1:0]        ohold,
  output logic                      odec_stall,
  output logic [CNT_W-1:0]          oregwr_pend,
  output logic [CNT_W-1:0]          ostore_pend,
  output logic                      oempty
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]               obubble_cnt,
  output logic [31:0]               oflush_cnt
`endif
);

  if (NSTAGES < 1 || NSTAGES > MAX_STAGES) begin : gBadStages
    $error("ctrl_pipe: NSTAGES=%0d outside 1..%0d", NSTAGES, MAX_STAGES);
  end
  if (CNT_W < cntWidthFor(NSTAGES)) begin : gBadCntW
    $error("ctrl_pipe: CNT_W=%0d too narrow for NSTAGES=%0d", CNT_W, NSTAGES);
  end
  if (REGWR_BIT >= CTRL_W || MEMWR_BIT >= CTRL_W) begin : gBadBit
    $error("ctrl_pipe: control bit index outside CTRL_W=%0d", CTRL_W);
  end

  logic [NSTAGES-1:0] hold;
  logic [NSTAGES-1:0] nextVld;
  logic [NSTAGES-1:0] nextRegWr;
  logic [NSTAGES-1:0] nextMemWr;
  logic [CNT_W-1:0]   regCnt;
  logic [CNT_W-1:0]   storeCnt;

  // A stall anywhere downstream freezes every earlier stage; flush does not break the chain.
  always_comb begin
    hold = '0;
    hold[NSTAGES-1] = istall[NSTAGES-1];
    for (int i = NSTAGES - 2; i >= 0; i--) begin
      hold[i] = istall[i] | hold[i+1];
    end
  end

  assign ohold      = hold;
  assign odec_stall = hold[0];

  for (genvar i = 0; i < NSTAGES; i++) begin : gStage
    if (i == 0) begin : gFirst
      ctrl_pipe_stage #(
        .CTRL_W    (CTRL_W),
        .REGWR_BIT (REGWR_BIT),
        .MEMWR_BIT (MEMWR_BIT)
      ) uStage (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .iflush     (iflush[i]),
        .ihold      (hold[i]),
        .iprevHold  (1'b0),
        .iprevCtrl  (ictrl_d),
        .iprevVld   (ivld_d),
        .octrl      (octrl[i*CTRL_W +: CTRL_W]),
        .ovld       (ovld[i]),
        .onextVld   (nextVld[i]),
        .onextRegWr (nextRegWr[i]),
        .onextMemWr (nextMemWr[i])
      );
    end else begin : gLater
      ctrl_pipe_stage #(
        .CTRL_W    (CTRL_W),
        .REGWR_BIT (REGWR_BIT),
        .MEMWR_BIT (MEMWR_BIT)
      ) uStage (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .iflush     (iflush[i]),
        .ihold      (hold[i]),
        .iprevHold  (hold[i-1]),
        .iprevCtrl  (octrl[(i-1)*CTRL_W +: CTRL_W]),
        .iprevVld   (ovld[i-1]),
        .octrl      (octrl[i*CTRL_W +: CTRL_W]),
        .ovld       (ovld[i]),
        .onextVld   (nextVld[i]),
        .onextRegWr (nextRegWr[i]),
        .onextMemWr (nextMemWr[i])
      );
    end
  end

  // Counts are taken from next-state contents so they line up with octrl after the edge.
  always_comb begin
    regCnt   = '0;
    storeCnt = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (nextRegWr[i] && regCnt != '1) regCnt = regCnt + 1'b1;
      if (nextMemWr[i] && storeCnt != '1) storeCnt = storeCnt + 1'b1;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oregwr_pend <= '0;
      ostore_pend <= '0;
      oempty      <= 1'b1;
    end else begin
      oregwr_pend <= regCnt;
      ostore_pend <= storeCnt;
      oempty      <= ~|nextVld;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  logic bubbleAny;
  logic flushHit;

  always_comb begin
    bubbleAny = 1'b0;
    for (int i = 1; i < NSTAGES; i++) begin
      bubbleAny = bubbleAny | (~iflush[i] & ~hold[i] & hold[i-1]);
    end
  end

  assign flushHit = |(iflush & ovld);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      obubble_cnt <= '0;
      oflush_cnt  <= '0;
    end else begin
      if (bubbleAny) obubble_cnt <= obubble_cnt + 32'd1;
      if (flushHit)  oflush_cnt  <= oflush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe (NSTAGES=3, CTRL_W=12); perf checks when CTRL_PIPE_PERF_EN is defined.
module tb_ctrl_pipe;

  localparam int NS = 3;
  localparam int CW = 12;
  localparam int CN = 4;

  logic             iclk;
  logic             irst_n;
  logic [CW-1:0]    ictrl_d;
  logic             ivld_d;
  logic [NS-1:0]    istall;
  logic [NS-1:0]    iflush;
  logic [NS*CW-1:0] octrl;
  logic [NS-1:0]    ovld;
  logic [NS-1:0]    ohold;
  logic             odec_stall;
  logic [CN-1:0]    oregwr_pend;
  logic [CN-1:0]    ostore_pend;
  logic             oempty;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]      obubble_cnt;
  logic [31:0]      oflush_cnt;
`endif

  int nAsserts = 0;
  int nFail    = 0;

  ctrl_pipe #(
    .NSTAGES   (NS),
    .CTRL_W    (CW),
    .REGWR_BIT (0),
    .MEMWR_BIT (4),
    .CNT_W     (CN)
  ) dut (
    .iclk        (iclk),
    .irst_n      (irst_n),
    .ictrl_d     (ictrl_d),
    .ivld_d      (ivld_d),
    .istall      (istall),
    .iflush      (iflush),
    .octrl       (octrl),
    .ovld        (ovld),
    .ohold       (ohold),
    .odec_stall  (odec_stall),
    .oregwr_pend (oregwr_pend),
    .ostore_pend (ostore_pend),
    .oempty      (oempty)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .obubble_cnt (obubble_cnt),
    .oflush_cnt  (oflush_cnt)
`endif
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] stg(input int i);
    return octrl[i*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  logic [CW-1:0] mC [NS];
  logic          mV [NS];
  logic [CW-1:0] w;
  int            expReg;
  int            expSt;

  initial begin
    irst_n  = 1'b0;
    ictrl_d = '0;
    ivld_d  = 1'b0;
    istall  = '0;
    iflush  = '0;
    repeat (2) tick();

    chk("rst_vld",   32'(ovld), 32'h0);
    chk("rst_ctrl",  32'(octrl), 32'h0);
    chk("rst_empty", 32'(oempty), 32'h1);
    chk("rst_regwr", 32'(oregwr_pend), 32'h0);
    chk("rst_store", 32'(ostore_pend), 32'h0);
`ifdef CTRL_PIPE_PERF_EN
    chk("rst_bubble", obubble_cnt, 32'h0);
    chk("rst_flushc", oflush_cnt, 32'h0);
`endif

    // Fill and drain
    ictrl_d = 12'h011; ivld_d = 1'b1;
    #2 irst_n = 1'b1;
    tick();
    chk("fill1_s0", 32'(stg(0)), 32'h011);
    chk("fill1_empty", 32'(oempty), 32'h0);
    ictrl_d = 12'h012;
    tick();
    ictrl_d = 12'h013;
    tick();
    chk("fill3_s2",    32'(stg(2)), 32'h011);
    chk("fill3_vld",   32'(ovld), 32'h7);
    chk("fill3_store", 32'(ostore_pend), 32'h3);
    chk("fill3_regwr", 32'(oregwr_pend), 32'h2);
    ictrl_d = 12'hFFF; ivld_d = 1'b0;
    tick();
    chk("drain4_s2",    32'(stg(2)), 32'h012);
    chk("drain4_s0",    32'(stg(0)), 32'h000);
    chk("drain4_store", 32'(ostore_pend), 32'h2);
    chk("drain4_regwr", 32'(oregwr_pend), 32'h1);
    tick();
    chk("drain5_s2",    32'(stg(2)), 32'h013);
    chk("drain5_empty", 32'(oempty), 32'h0);
    tick();
    chk("drain6_empty", 32'(oempty), 32'h1);
    chk("drain6_vld",   32'(ovld), 32'h0);
    chk("drain6_store", 32'(ostore_pend), 32'h0);

    // Stall propagation: stalling stage 1 holds 0..1 and bubbles stage 2
    ivld_d = 1'b1;
    ictrl_d = 12'h021; tick();
    ictrl_d = 12'h022; tick();
    ictrl_d = 12'h023; tick();
    chk("stl_pre_dec", 32'(odec_stall), 32'h0);
    ictrl_d = 12'h024; istall = 3'b010;
    chk("stl_hold", 32'(ohold), 32'h3);
    chk("stl_dec",  32'(odec_stall), 32'h1);
    repeat (2) begin
      tick();
      chk("stl_vld", 32'(ovld), 32'h3);
      chk("stl_s2",  32'(stg(2)), 32'h000);
      chk("stl_s1",  32'(stg(1)), 32'h022);
      chk("stl_s0",  32'(stg(0)), 32'h023);
    end
    istall = '0;
    tick();
    chk("stl_rel_s2",    32'(stg(2)), 32'h022);
    chk("stl_rel_s0",    32'(stg(0)), 32'h024);
    chk("stl_rel_regwr", 32'(oregwr_pend), 32'h1);

    // Flush beats stall on stage 0; stage 1 gets a bubble
    ictrl_d = 12'h025; iflush = 3'b001; istall = 3'b001;
    tick();
    chk("fvs_s0",  32'(stg(0)), 32'h000);
    chk("fvs_vld", 32'(ovld), 32'h4);
    chk("fvs_s2",  32'(stg(2)), 32'h023);
    iflush = '0; istall = '0;
    tick();
    chk("fvs_next_vld", 32'(ovld), 32'h1);
    chk("fvs_next_s1",  32'(stg(1)), 32'h000);

    // Pending counts vs. a shift-register reference model
    mC[0] = 12'h025; mV[0] = 1'b1;
    mC[1] = '0;      mV[1] = 1'b0;
    mC[2] = '0;      mV[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w = (k % 2 == 0) ? 12'h001 : 12'h010;
      ictrl_d = w;
      tick();
      mC[2] = mC[1]; mV[2] = mV[1];
      mC[1] = mC[0]; mV[1] = mV[0];
      mC[0] = w;     mV[0] = 1'b1;
      expReg = 0; expSt = 0;
      for (int j = 0; j < NS; j++) begin
        if (mV[j] && mC[j][0]) expReg++;
        if (mV[j] && mC[j][4]) expSt++;
      end
      chk("pend_regwr", 32'(oregwr_pend), 32'(expReg));
      chk("pend_store", 32'(ostore_pend), 32'(expSt));
    end

    // Asynchronous reset between edges
    #2 irst_n = 1'b0;
    #1;
    chk("arst_vld",   32'(ovld), 32'h0);
    chk("arst_ctrl",  32'(octrl), 32'h0);
    chk("arst_empty", 32'(oempty), 32'h1);
    chk("arst_regwr", 32'(oregwr_pend), 32'h0);
    chk("arst_store", 32'(ostore_pend), 32'h0);
    #1 irst_n = 1'b1;

`ifdef CTRL_PIPE_PERF_EN
    ictrl_d = 12'h031; ivld_d = 1'b1;
    repeat (3) tick();
    // Stalling the Memory stage drops one bubble into Writeback per stall cycle
    repeat (5) begin
      istall = 3'b010; tick();
      istall = 3'b000; tick();
    end
    iflush = 3'b001; tick();
    iflush = 3'b100; tick();
    iflush = 3'b010; tick();
    iflush = 3'b000; tick();
    chk("perf_bubble", obubble_cnt, 32'd5);
    chk("perf_flush",  oflush_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
